// File: rtl/xs3_to_bcd_dec_if.sv
// Handshake bundle for the Excess-3 to BCD decoder: digit input side and packed-frame output side.
// master = digit producer / frame consumer, slave = decoder.
interface xs3_to_bcd_dec_if #(
    parameter int unsigned DIGITS = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [3:0]            in_digit;
    logic                  in_last;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   out_bcd;
    logic [3:0]            out_count;
    logic                  out_err;

    modport master (
        output in_valid, in_digit, in_last, out_ready,
        input  in_ready, out_valid, out_bcd, out_count, out_err
    );

    modport slave (
        input  in_valid, in_digit, in_last, out_ready,
        output in_ready, out_valid, out_bcd, out_count, out_err
    );
endinterface

// File: rtl/xs3_to_bcd_dec.sv
// Digit-serial Excess-3 to packed BCD decoder, MSD first, right-aligned output frame.
// Optional invalid-code detection is enabled by defining XS3_DEC_ERR_EN.
module xs3_to_bcd_dec #(
    parameter int unsigned DIGITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    xs3_to_bcd_dec_if.slave  io_bus
);
    localparam int unsigned W  = 4 * DIGITS;
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_OUT   = 2'd2
    } state_t;

    state_t          r_state;
    logic [W-1:0]    r_acc;
    logic [CW-1:0]   r_cnt;
    logic            r_in_ready;
    logic            r_out_valid;
    logic [W-1:0]    r_out_bcd;
    logic [CW-1:0]   r_out_count;

    logic            w_accept;
    logic            w_done;
    logic            w_close;
    logic [3:0]      w_dec;
    logic [3:0]      w_nib;
    logic [CW-1:0]   w_cnt_next;
    logic [W-1:0]    w_acc_next;
    logic            w_err_next;

    assign w_accept   = io_bus.in_valid & r_in_ready;
    assign w_done     = r_out_valid & io_bus.out_ready;
    assign w_dec      = io_bus.in_digit - 4'd3;
    assign w_cnt_next = r_cnt + CW'(1);
    // A frame closes on in_last or as soon as it reaches DIGITS digits.
    assign w_close    = io_bus.in_last | (w_cnt_next == CW'(DIGITS));

`ifdef XS3_DEC_ERR_EN
    logic r_err;
    logic r_out_err;
    logic w_invalid;

    assign w_invalid  = (io_bus.in_digit < 4'd3) | (io_bus.in_digit > 4'd12);
    assign w_nib      = w_invalid ? 4'hF : w_dec;
    assign w_err_next = r_err | w_invalid;
    assign io_bus.out_err = r_out_err;
`else
    assign w_nib      = w_dec;
    assign w_err_next = 1'b0;
    assign io_bus.out_err = 1'b0;
`endif

    generate
        if (DIGITS == 1) begin : g_one
            assign w_acc_next = w_nib;
        end else begin : g_multi
            assign w_acc_next = {r_acc[W-5:0], w_nib};
        end
    endgenerate

    // Frame FSM with registered handshake and output payload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_bcd   <= '0;
            r_out_count <= '0;
`ifdef XS3_DEC_ERR_EN
            r_err       <= 1'b0;
            r_out_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_ACCUM: begin
                    if (w_accept) begin
                        r_acc <= w_acc_next;
                        r_cnt <= w_cnt_next;
`ifdef XS3_DEC_ERR_EN
                        r_err <= w_err_next;
`endif
                        if (w_close) begin
                            r_state     <= S_OUT;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_out_bcd   <= w_acc_next;
                            r_out_count <= w_cnt_next;
`ifdef XS3_DEC_ERR_EN
                            r_out_err   <= w_err_next;
`endif
                        end else begin
                            r_state <= S_ACCUM;
                        end
                    end
                end
                S_OUT: begin
                    if (w_done) begin
                        r_state     <= S_IDLE;
                        r_acc       <= '0;
                        r_cnt       <= '0;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
`ifdef XS3_DEC_ERR_EN
                        r_err       <= 1'b0;
`endif
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign io_bus.in_ready  = r_in_ready;
    assign io_bus.out_valid = r_out_valid;
    assign io_bus.out_bcd   = r_out_bcd;
    assign io_bus.out_count = r_out_count;

endmodule
